// File: rtl/reg_wb_pkg.sv
// Shared widths and the long-latency queue entry for the register-file write controller.
package reg_wb_pkg;
  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  live;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Pipeline, long-latency and register-file write signals of reg_wb_ctrl.
// REG_WB_FWD_EN adds the forwarding copy of the output stage.
interface reg_wb_ctrl_if
  import reg_wb_pkg::*;
#(
  parameter int XLEN = reg_wb_pkg::XLEN
);
  logic                  pipe_valid;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [XLEN-1:0]       pipe_data;
  logic                  ll_valid;
  logic                  ll_ready;
  logic [REG_ADDR_W-1:0] ll_rd;
  logic [XLEN-1:0]       ll_data;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  wr_enable;
  logic [NUM_REGS-1:0]   busy_mask;
  logic                  stall_req;
`ifdef REG_WB_FWD_EN
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [XLEN-1:0]       fwd_data;
`endif

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
    output ll_ready, wr_addr, wr_data, wr_enable, busy_mask, stall_req
`ifdef REG_WB_FWD_EN
    , output fwd_valid, fwd_addr, fwd_data
`endif
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
    input  ll_ready, wr_addr, wr_data, wr_enable, busy_mask, stall_req
`ifdef REG_WB_FWD_EN
    , input fwd_valid, fwd_addr, fwd_data
`endif
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency results; entries can be killed by destination register.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output wb_entry_t             head,
  output logic                  empty,
  output logic                  full,
  output logic [REG_ADDR_W-1:0] ent_rd [DEPTH],
  output logic [DEPTH-1:0]      ent_live
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign head  = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i]   = mem[i].rd;
      ent_live[i] = mem[i].live;
    end
  end

  // Free slots always hold live=0, so ent_live needs no occupancy qualification.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill && mem[i].rd == kill_rd) mem[i].live <= 1'b0;
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + PW'(1);
      end
      if (push) begin
        mem[wr_ptr].rd   <= push_rd;
        mem[wr_ptr].data <= push_data;
        mem[wr_ptr].live <= !(kill && kill_rd == push_rd);
        wr_ptr           <= wr_ptr + PW'(1);
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-port arbiter: pipeline writeback vs. queued long-latency results.
// Define REG_WB_FWD_EN to expose fwd_* and drop the output stage from busy_mask.
module reg_wb_ctrl
  import reg_wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = reg_wb_pkg::XLEN
) (
  input  logic          clk,
  input  logic          rst,
  reg_wb_ctrl_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             head;
  logic                  empty;
  logic                  full;
  logic [REG_ADDR_W-1:0] ent_rd [DEPTH];
  logic [DEPTH-1:0]      ent_live;
  logic                  push;
  logic                  pop;
  logic                  pipe_wr;
  logic                  head_wr;
  logic [CW-1:0]         starve_cnt;
  logic [CW-1:0]         starve_nxt;
  logic                  stall_q;
  logic                  wr_en_q;
  logic [REG_ADDR_W-1:0] wr_addr_q;
  logic [XLEN-1:0]       wr_data_q;
  logic [NUM_REGS-1:0]   mask;

  assign push    = bus.ll_valid && !full && bus.ll_rd != '0;
  assign pipe_wr = bus.pipe_valid && bus.pipe_rd != '0;
  // With stall_req honoured the pipe is idle, so one rule covers both head-write priorities.
  assign head_wr = !empty && head.live && !pipe_wr;
  assign pop     = !empty && (head_wr || !head.live);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (bus.ll_rd),
    .push_data (bus.ll_data),
    .pop       (pop),
    .kill      (pipe_wr),
    .kill_rd   (bus.pipe_rd),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .ent_rd    (ent_rd),
    .ent_live  (ent_live)
  );

  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || head_wr)
      starve_nxt = '0;
    else if (head.live && starve_cnt != CW'(STARVE_LIMIT))
      starve_nxt = starve_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      stall_q    <= (starve_nxt >= CW'(STARVE_LIMIT));
      wr_en_q    <= pipe_wr || head_wr;
      if (pipe_wr) begin
        wr_addr_q <= bus.pipe_rd;
        wr_data_q <= bus.pipe_data;
      end else if (head_wr) begin
        wr_addr_q <= head.rd;
        wr_data_q <= head.data;
      end
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_live[i]) mask[ent_rd[i]] = 1'b1;
`ifndef REG_WB_FWD_EN
    if (wr_en_q) mask[wr_addr_q] = 1'b1;
`endif
    mask[0] = 1'b0;
  end

  assign bus.ll_ready  = !full;
  assign bus.wr_enable = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy_mask = mask;
  assign bus.stall_req = stall_q;
`ifdef REG_WB_FWD_EN
  assign bus.fwd_valid = wr_en_q;
  assign bus.fwd_addr  = wr_addr_q;
  assign bus.fwd_data  = wr_data_q;
`endif

  a_no_pipe_during_stall: assert property (@(posedge clk) disable iff (rst)
    !(stall_q && bus.pipe_valid));
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Scoreboard bench for reg_wb_ctrl: a cycle model queues expected writes, drained as wr_* fires.
module tb_reg_wb_ctrl;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  typedef struct { logic [4:0] rd; logic [63:0] data; bit live; } ment_t;
  typedef struct { logic [4:0] addr; logic [63:0] data; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_ctrl_if #(.XLEN(64)) bus();
  reg_wb_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .XLEN(64)) dut (
    .clk (clk), .rst (rst), .bus (bus));

  ment_t      mq[$];
  wr_t        exp_q[$];
  int         m_cnt;
  bit         m_stall;
  bit         m_wr_en;
  logic [4:0] m_wr_addr;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic drive(input bit pv, input logic [4:0] prd, input logic [63:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [63:0] ld);
    bus.pipe_valid = pv; bus.pipe_rd = prd; bus.pipe_data = pd;
    bus.ll_valid   = lv; bus.ll_rd   = lrd; bus.ll_data   = ld;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); exp_q.delete();
    m_cnt = 0; m_stall = 0; m_wr_en = 0; m_wr_addr = 0;
  endtask

  // Check outputs of the current cycle, apply one cycle of stimulus, advance the model.
  task automatic step(input bit pv, input logic [4:0] prd, input logic [63:0] pd,
                      input bit lv, input logic [4:0] lrd, input logic [63:0] ld);
    logic [31:0] emask;
    wr_t   w;
    ment_t e;
    bit pw, push, has_head, hlive, hw, pop;
    chk("wr_enable", bus.wr_enable, m_wr_en);
    if (bus.wr_enable === 1'b1) begin
      chk("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("wr_addr", bus.wr_addr, w.addr);
        chk("wr_data", bus.wr_data, w.data);
      end
    end
    emask = '0;
    foreach (mq[i]) if (mq[i].live) emask[mq[i].rd] = 1'b1;
`ifndef REG_WB_FWD_EN
    if (m_wr_en) emask[m_wr_addr] = 1'b1;
`endif
    emask[0] = 1'b0;
    chk("busy_mask", bus.busy_mask, emask);
    chk("ll_ready", bus.ll_ready, mq.size() < DEPTH);
    chk("stall_req", bus.stall_req, m_stall);

    pv = pv && !m_stall;
    drive(pv, prd, pd, lv, lrd, ld);

    pw       = pv && prd != 0;
    push     = lv && (mq.size() < DEPTH) && lrd != 0;
    has_head = mq.size() != 0;
    hlive    = has_head && mq[0].live;
    hw       = hlive && !pw;
    pop      = hw || (has_head && !mq[0].live);
    m_wr_en  = pw || hw;
    if (pw) begin
      w.addr = prd; w.data = pd; m_wr_addr = prd; exp_q.push_back(w);
    end else if (hw) begin
      w.addr = mq[0].rd; w.data = mq[0].data; m_wr_addr = mq[0].rd; exp_q.push_back(w);
    end
    if (!has_head || hw) m_cnt = 0;
    else if (hlive) m_cnt++;
    m_stall = (m_cnt >= STARVE_LIMIT);
    foreach (mq[i]) if (pw && mq[i].rd == prd) mq[i].live = 0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.rd = lrd; e.data = ld; e.live = !(pw && prd == lrd);
      mq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (mq.size() != 0 || m_wr_en); i++) idle();
    idle();
    chk("drain_busy", bus.busy_mask, 0);
  endtask

  initial begin
    int idx;
    bit acc;
    logic [4:0] full_rd [5];
    full_rd = '{11, 12, 13, 14, 15};
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_ll_ready", bus.ll_ready, 1);
    idle();

    // pipe only
    step(1, 5, 64'hA5, 0, 0, 0);
    chk("pipe_addr", bus.wr_addr, 5);
    chk("pipe_data", bus.wr_data, 64'hA5);
    chk("pipe_bit5", bus.busy_mask[5], 1);
    idle();
    chk("pipe_bit5_clr", bus.busy_mask[5], 0);

    // contention: pipe x3 first, then queued x7
    step(1, 3, 64'h33, 1, 7, 64'h11);
    chk("cont_first", bus.wr_addr, 3);
    chk("cont_bit7_t1", bus.busy_mask[7], 1);
    idle();
    chk("cont_second", bus.wr_addr, 7);
    chk("cont_bit7_t2", bus.busy_mask[7], 1);
    idle();
    chk("cont_bit7_gone", bus.busy_mask[7], 0);
    drain();

    // WAW kill
    step(0, 0, 0, 1, 9, 64'h1);
    step(1, 9, 64'h2, 0, 0, 0);
    chk("waw_data", bus.wr_data, 64'h2);
    idle();
    chk("waw_no_old", bus.wr_enable, 0);
    drain();

    // full FIFO under continuous pipe traffic
    idx = 0;
    for (int c = 0; c < 70; c++) begin
      acc = (idx < 5) && (mq.size() < DEPTH);
      step(1, 5'(20 + c % 8), 64'(c), idx < 5, (idx < 5) ? full_rd[idx] : 5'd0,
           64'h100 + 64'(idx));
      if (acc) begin
        idx++;
        if (idx == 4) chk("full_ready_low", bus.ll_ready, 0);
      end
    end
    chk("full_all_pushed", idx, 5);
    drain();

    // starvation
    step(0, 0, 0, 1, 4, 64'h44);
    for (int k = 0; k < 10; k++) begin
      chk("starve_stall", bus.stall_req, (k == STARVE_LIMIT) ? 1 : 0);
      step(1, 10, 64'(k), 0, 0, 0);
      if (k == STARVE_LIMIT) chk("starve_head_wr", bus.wr_addr, 4);
    end
    drain();

    // reset mid-drain
    for (int k = 0; k < 3; k++) step(1, 30, 0, 1, 5'(k + 1), 64'(k));
    do_reset();
    chk("rst2_wr_enable", bus.wr_enable, 0);
    chk("rst2_busy", bus.busy_mask, 0);
    chk("rst2_ready", bus.ll_ready, 1);
    for (int k = 0; k < 4; k++) idle();

    // random traffic
    for (int c = 0; c < 300; c++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), {$urandom, $urandom},
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), {$urandom, $urandom});
    drain();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
